// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS multiply/divide unit.
//   muldiv_op_t    : operation code presented on the unit's op input (codes 6 and 7 reserved)
//   muldiv_state_t : sequencing states of the iterative engine
package mips_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } muldiv_state_t;

    // Signed ops work on magnitudes and sign-correct the result afterwards.
    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the core controller and the multiply/divide unit.
//   start, op, a, b            : request (controller -> unit)
//   busy, done, div_by_zero    : status (unit -> controller)
//   hi, lo                     : architectural HI/LO registers (unit -> controller)
// Modports: master = controller side, slave = unit side.
interface mips_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_twos_negate.sv
// Combinational conditional two's-complement negation.
//   value_i  : input word
//   neg_i    : 1 = output -value_i, 0 = pass value_i through
//   result_o : result
module mips_twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] result_o
);
    always_comb begin
        result_o = value_i;
        if (neg_i) begin
            result_o = (~value_i) + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use one-bit-per-cycle shift-add, DIV/DIVU use restoring division; both take
// WIDTH RUN cycles plus one FIX cycle for sign correction, then pulse done. MTHI/MTLO write
// HI/LO directly from IDLE.
//   clk, rst : clock, asynchronous active-high reset
//   mdu      : slave side of mips_muldiv_unit_if (start/op/a/b in; busy/done/div_by_zero/hi/lo out)
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    mips_muldiv_unit_if.slave mdu
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    muldiv_state_t    state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             qsign_q, qsign_d;   // product or quotient must be negated
    logic             rsign_q, rsign_d;   // remainder must be negated
    logic             dbz_q, dbz_d;       // current divide has a zero divisor
    logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_flag_q, dbz_flag_d;

    muldiv_op_t op;
    logic       accept, is_md_op, is_div_op, is_signed_op, b_zero, neg_a_en, neg_b_en;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op           = muldiv_op_t'(mdu.op);
    assign accept       = mdu.start && (state_q == StIdle);
    assign is_md_op     = !mdu.op[2];
    assign is_div_op    = (op == OpDiv) || (op == OpDivu);
    assign is_signed_op = op_is_signed(op);
    assign b_zero       = (mdu.b == '0);
    // With a zero divisor the raw dividend must survive to HI, so no magnitude is taken.
    assign neg_a_en     = is_signed_op && mdu.a[WIDTH-1] && !(is_div_op && b_zero);
    assign neg_b_en     = is_signed_op && mdu.b[WIDTH-1];

    mips_twos_negate #(.WIDTH(WIDTH)) u_mag_a (
        .value_i  (mdu.a),
        .neg_i    (neg_a_en),
        .result_o (mag_a)
    );

    mips_twos_negate #(.WIDTH(WIDTH)) u_mag_b (
        .value_i  (mdu.b),
        .neg_i    (neg_b_en),
        .result_o (mag_b)
    );

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic               q_bit;
    logic [WIDTH-1:0]   new_rem;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
    assign q_bit    = !diff[WIDTH+1];
    // A zero divisor never borrows: quotient becomes all ones, remainder the dividend.
    assign new_rem  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_next = {new_rem, acc_q[WIDTH-2:0], q_bit};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    mips_twos_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value_i  (acc_q),
        .neg_i    (qsign_q),
        .result_o (prod_fix)
    );

    mips_twos_negate #(.WIDTH(WIDTH)) u_fix_quot (
        .value_i  (acc_q[WIDTH-1:0]),
        .neg_i    (qsign_q && !dbz_q),
        .result_o (quot_fix)
    );

    mips_twos_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i  (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i    (rsign_q && !dbz_q),
        .result_o (rem_fix)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        dbz_d      = dbz_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_flag_d = dbz_flag_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept && is_md_op) begin
                    is_div_d   = is_div_op;
                    opnd_d     = is_div_op ? mag_b : mag_a;
                    acc_d      = is_div_op ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    qsign_d    = is_signed_op && (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
                    rsign_d    = is_signed_op && mdu.a[WIDTH-1];
                    dbz_d      = is_div_op && b_zero;
                    dbz_flag_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = StRun;
                end else if (accept && (op == OpMthi || op == OpMtlo)) begin
                    if (op == OpMthi) begin
                        hi_d = mdu.a;
                    end else begin
                        lo_d = mdu.a;
                    end
                    dbz_flag_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    lo_d       = quot_fix;
                    hi_d       = rem_fix;
                    dbz_flag_d = dbz_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun) || (state_d == StFix);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            dbz_q      <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            dbz_q      <= dbz_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dbz_flag_q;
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32): the stimulus thread pushes expected
// HI/LO/div_by_zero results; a monitor pops and compares them whenever done is seen.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    logic clk;
    logic rst;

    mips_muldiv_unit_if #(.WIDTH(32)) mdu_if ();

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_res(input string nm, input logic [31:0] h, input logic [31:0] l,
                              input logic d);
        exp_t e;
        e.name = nm;
        e.hi   = h;
        e.lo   = l;
        e.dbz  = d;
        sb_q.push_back(e);
        m_hi = h;
        m_lo = l;
    endtask

    // Drives one start pulse; returns 1 ns after the edge that samples it.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        mdu_if.start = 1'b1;
        mdu_if.op    = o;
        mdu_if.a     = av;
        mdu_if.b     = bv;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
    endtask

    // Waits (bounded) for done, then steps past the DONE cycle back to IDLE.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!mdu_if.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mdu_if.done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no done within 100 cycles, expected done", nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] h, input logic [31:0] l,
                       input logic d);
        expect_res(nm, h, l, d);
        issue(o, av, bv);
        wait_done(nm);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mdu_if.done) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done",
                         mdu_if.hi, mdu_if.lo);
            end else begin
                e = sb_q.pop_front();
                if ({mdu_if.hi, mdu_if.lo, mdu_if.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
                    n_miss++;
                    $display("FAIL %s: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                             e.name, mdu_if.hi, mdu_if.lo, mdu_if.div_by_zero,
                             e.hi, e.lo, e.dbz);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        logic busy_ok;

        rst          = 1'b1;
        mdu_if.start = 1'b0;
        mdu_if.op    = 3'd0;
        mdu_if.a     = '0;
        mdu_if.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              65'({mdu_if.busy, mdu_if.done, mdu_if.div_by_zero, mdu_if.hi, mdu_if.lo}),
              65'(0));
        rst = 1'b0;

        // MULTU 7*6 with latency and busy profile.
        expect_res("multu_7x6", 32'h0, 32'd42, 1'b0);
        issue(OpMultu, 32'd7, 32'd6);
        lat     = 0;
        busy_ok = 1'b1;
        while (!mdu_if.done && lat < 100) begin
            if (!mdu_if.busy) busy_ok = 1'b0;
            if (mdu_if.hi !== 32'h0 || mdu_if.lo !== 32'h0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("multu_done_latency", 65'(lat), 65'(33));
        check("busy_and_hilo_hold_during_run", 65'(busy_ok), 65'(1));
        check("busy_low_with_done", 65'(mdu_if.busy), 65'(0));
        @(posedge clk);
        #1;

        run("mult_m3x5", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run("div_m7d2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("div_7dm2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run("div_min_dm1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run("mult_m1xm1", OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        run("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run("divu_100d7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Divide by zero: flag stays up in IDLE and the next accepted start clears it.
        run("divu_by_zero", OpDivu, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("dbz_held_in_idle", 65'(mdu_if.div_by_zero), 65'(1));
        expect_res("multu_after_dbz", 32'h0, 32'd12, 1'b0);
        issue(OpMultu, 32'd3, 32'd4);
        check("dbz_cleared_on_start", 65'(mdu_if.div_by_zero), 65'(0));
        wait_done("multu_after_dbz");
        run("div_signed_by_zero", OpDiv, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF,
            1'b1);

        // MTHI / MTLO: immediate register update, no busy.
        expect_res("mthi", 32'hDEAD_BEEF, m_lo, 1'b0);
        issue(OpMthi, 32'hDEAD_BEEF, 32'h0);
        check("mthi_hi_next_cycle", 65'(mdu_if.hi), 65'(32'hDEAD_BEEF));
        check("mthi_busy_low", 65'(mdu_if.busy), 65'(0));
        wait_done("mthi");
        run("mtlo", OpMtlo, 32'h0000_55AA, 32'h0, 32'hDEAD_BEEF, 32'h0000_55AA, 1'b0);

        // Reserved codes: no done (monitor), HI/LO untouched.
        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        repeat (5) @(posedge clk);
        #1;
        check("reserved_op_hilo", 65'({mdu_if.hi, mdu_if.lo}), 65'({m_hi, m_lo}));

        // Second start mid-RUN is dropped.
        expect_res("multu_2p16_sq", 32'h1, 32'h0, 1'b0);
        issue(OpMultu, 32'h0001_0000, 32'h0001_0000);
        repeat (5) @(posedge clk);
        issue(OpDiv, 32'd100, 32'd7);
        wait_done("multu_2p16_sq");
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_hilo", 65'({mdu_if.hi, mdu_if.lo}), 65'({32'h1, 32'h0}));
        check("ignored_start_idle", 65'(mdu_if.busy), 65'(0));

        // Asynchronous reset at cycle 10 of a MULT.
        issue(OpMult, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("reset_midrun_outputs",
              65'({mdu_if.busy, mdu_if.done, mdu_if.hi, mdu_if.lo}), 65'(0));
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("no_done_after_reset", 65'({mdu_if.busy, mdu_if.hi, mdu_if.lo}), 65'(0));

        run("multu_after_reset", OpMultu, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

        check("scoreboard_drained", 65'(sb_q.size()), 65'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
